// File: rtl/game_level_sequencer_pkg.sv
// Shared constants, state encodings and the level position table for the
// game level sequencer.
package game_level_sequencer_pkg;

    localparam int MAX_FAILHOLE_NUM    = 5;
    localparam int LEVEL_COUNT         = 4;
    localparam int LEVEL_BITS          = $clog2(LEVEL_COUNT);
    localparam int DEFAULT_START_LIVES = 3;
    localparam int DEFAULT_HOLD_FRAMES = 120;
    localparam int PIXEL_COORD_BIT     = 10;
    localparam int HOLE_ENTRY_W        = 2 * PIXEL_COORD_BIT;
    localparam int IDX_BITS            = 3;
    localparam int ROM_ADDR_W          = LEVEL_BITS + IDX_BITS;

    // State encodings, also exported on o_state for LEDs.
    localparam logic [2:0] ST_LOAD      = 3'd0;
    localparam logic [2:0] ST_READY     = 3'd1;
    localparam logic [2:0] ST_PLAY      = 3'd2;
    localparam logic [2:0] ST_WIN_HOLD  = 3'd3;
    localparam logic [2:0] ST_FAIL_HOLD = 3'd4;
    localparam logic [2:0] ST_GAME_OVER = 3'd5;
    localparam logic [2:0] ST_GAME_DONE = 3'd6;

    // Packs one hole position as {x, y}.
    function automatic logic [HOLE_ENTRY_W-1:0] hole(input int x, input int y);
        return {PIXEL_COORD_BIT'(x), PIXEL_COORD_BIT'(y)};
    endfunction

    // Level table, address {level, idx}: idx 0 is the win hole, idx k is
    // fail hole k-1, idx 6..7 are unused and read as zero.
    function automatic logic [HOLE_ENTRY_W-1:0] rom_entry(input logic [ROM_ADDR_W-1:0] addr);
        case (addr)
            5'd0:    return hole(200, 100);
            5'd1:    return hole(250,  70);
            5'd2:    return hole(300, 150);
            5'd3:    return hole(120, 220);
            5'd4:    return hole(400, 300);
            5'd5:    return hole(500,  60);
            5'd8:    return hole(560, 400);
            5'd9:    return hole(100, 100);
            5'd10:   return hole(320, 240);
            5'd11:   return hole(450, 120);
            5'd12:   return hole(200, 380);
            5'd13:   return hole(600, 200);
            5'd16:   return hole( 80, 420);
            5'd17:   return hole(160, 300);
            5'd18:   return hole(240, 180);
            5'd19:   return hole(360, 360);
            5'd20:   return hole(480, 240);
            5'd21:   return hole(560,  80);
            5'd24:   return hole(320,  40);
            5'd25:   return hole( 60,  60);
            5'd26:   return hole(180, 140);
            5'd27:   return hole(300, 260);
            5'd28:   return hole(420, 340);
            5'd29:   return hole(540, 420);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/game_level_sequencer_if.sv
// Bundle of the sequencer's game-side inputs and status/position outputs.
interface game_level_sequencer_if;
    import game_level_sequencer_pkg::*;

    logic                                        i_screenend;
    logic                                        i_win;
    logic                                        i_fail;
    logic                                        i_start;
    logic                                        o_game_rst;
    logic                                        o_playing;
    logic [PIXEL_COORD_BIT-1:0]                  o_wh_pos_x;
    logic [PIXEL_COORD_BIT-1:0]                  o_wh_pos_y;
    logic [PIXEL_COORD_BIT*MAX_FAILHOLE_NUM-1:0] o_fh_pos_x;
    logic [PIXEL_COORD_BIT*MAX_FAILHOLE_NUM-1:0] o_fh_pos_y;
    logic [LEVEL_BITS-1:0]                       o_level;
    logic [2:0]                                  o_lives;
    logic [2:0]                                  o_state;

    modport master (
        output i_screenend, i_win, i_fail, i_start,
        input  o_game_rst, o_playing, o_wh_pos_x, o_wh_pos_y,
               o_fh_pos_x, o_fh_pos_y, o_level, o_lives, o_state
    );

    modport slave (
        input  i_screenend, i_win, i_fail, i_start,
        output o_game_rst, o_playing, o_wh_pos_x, o_wh_pos_y,
               o_fh_pos_x, o_fh_pos_y, o_level, o_lives, o_state
    );

endinterface

// File: rtl/game_level_sequencer_rom.sv
// Synchronous level-position ROM: one cycle from address to data.
module level_rom
    import game_level_sequencer_pkg::*;
(
    input  logic                    CLK,
    input  logic [ROM_ADDR_W-1:0]   addr,
    output logic [HOLE_ENTRY_W-1:0] data
);

    logic [HOLE_ENTRY_W-1:0] data_q;
    logic [HOLE_ENTRY_W-1:0] data_d;

    // Table lookup for the presented address.
    always_comb begin
        data_d = rom_entry(addr);
    end

    // Output register; the consumer only samples it during LOAD.
    // NOTE: constant-table read register carries no reset -- its contents are
    // always valid one cycle after the address, so a reset adds nothing.
    always_ff @(posedge CLK) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/game_level_sequencer.sv
// Game level sequencer: loads hole positions per level, gates play with a
// start edge, tracks lives and pauses a fixed number of frames after each
// win or fail before advancing, retrying or ending the game.
module game_level_sequencer
    import game_level_sequencer_pkg::*;
#(
    parameter int START_LIVES = DEFAULT_START_LIVES,
    parameter int HOLD_FRAMES = DEFAULT_HOLD_FRAMES
) (
    input logic                   CLK,
    input logic                   rst_n,
    game_level_sequencer_if.slave bus
);

    localparam int                  FH_W      = PIXEL_COORD_BIT * MAX_FAILHOLE_NUM;
    localparam logic [IDX_BITS-1:0] LOAD_LAST = IDX_BITS'(MAX_FAILHOLE_NUM + 1);

    logic [2:0]                 state_q,      state_d;
    logic [IDX_BITS-1:0]        load_idx_q,   load_idx_d;
    logic [LEVEL_BITS-1:0]      level_q,      level_d;
    logic [2:0]                 lives_q,      lives_d;
    logic [7:0]                 hold_cnt_q,   hold_cnt_d;
    logic                       start_prev_q, start_prev_d;
    logic                       game_rst_q,   game_rst_d;
    logic                       playing_q,    playing_d;
    logic [PIXEL_COORD_BIT-1:0] wh_x_q,       wh_x_d;
    logic [PIXEL_COORD_BIT-1:0] wh_y_q,       wh_y_d;
    logic [FH_W-1:0]            fh_x_q,       fh_x_d;
    logic [FH_W-1:0]            fh_y_q,       fh_y_d;

    logic [HOLE_ENTRY_W-1:0]    rom_data;
    logic [PIXEL_COORD_BIT-1:0] rom_x;
    logic [PIXEL_COORD_BIT-1:0] rom_y;
    logic                       start_edge;
    logic                       hold_done;

    assign start_edge     = bus.i_start & ~start_prev_q;
    assign hold_done      = bus.i_screenend && (hold_cnt_q == 8'(HOLD_FRAMES - 1));
    assign {rom_x, rom_y} = rom_data;

    level_rom u_level_rom (
        .CLK  (CLK),
        .addr ({level_q, load_idx_q}),
        .data (rom_data)
    );

    // Next-state, level, lives and hold-counter logic plus registered output decode.
    // NOTE: every always_comb output gets its hold value first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        load_idx_d   = load_idx_q;
        level_d      = level_q;
        lives_d      = lives_q;
        hold_cnt_d   = hold_cnt_q;
        start_prev_d = bus.i_start;

        case (state_q)
            ST_LOAD: begin
                if (load_idx_q == LOAD_LAST) begin
                    state_d    = ST_READY;
                    load_idx_d = '0;
                end else begin
                    load_idx_d = load_idx_q + 1'b1;
                end
            end
            ST_READY: begin
                if (start_edge) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (bus.i_fail) begin
                    state_d    = ST_FAIL_HOLD;
                    hold_cnt_d = '0;
                    if (lives_q != 3'd0) begin
                        lives_d = lives_q - 3'd1;
                    end
                end else if (bus.i_win) begin
                    state_d    = ST_WIN_HOLD;
                    hold_cnt_d = '0;
                end
            end
            ST_WIN_HOLD: begin
                if (bus.i_screenend) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
                if (hold_done) begin
                    if (level_q == LEVEL_BITS'(LEVEL_COUNT - 1)) begin
                        state_d = ST_GAME_DONE;
                    end else begin
                        level_d    = level_q + 1'b1;
                        load_idx_d = '0;
                        state_d    = ST_LOAD;
                    end
                end
            end
            ST_FAIL_HOLD: begin
                if (bus.i_screenend) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
                if (hold_done) begin
                    if (lives_q == 3'd0) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        load_idx_d = '0;
                        state_d    = ST_LOAD;
                    end
                end
            end
            ST_GAME_OVER, ST_GAME_DONE: begin
                if (start_edge) begin
                    level_d    = '0;
                    lives_d    = 3'(START_LIVES);
                    load_idx_d = '0;
                    state_d    = ST_LOAD;
                end
            end
            default: begin
                state_d    = ST_LOAD;
                load_idx_d = '0;
            end
        endcase

        // Decoded from the next state so the outputs flip with the state itself.
        game_rst_d = !((state_d == ST_PLAY) || (state_d == ST_WIN_HOLD) ||
                       (state_d == ST_FAIL_HOLD));
        playing_d  = (state_d == ST_PLAY);
    end

    // Position write-back: the ROM word for idx n arrives while load_idx is n+1.
    always_comb begin
        wh_x_d = wh_x_q;
        wh_y_d = wh_y_q;
        fh_x_d = fh_x_q;
        fh_y_d = fh_y_q;
        if (state_q == ST_LOAD) begin
            if (load_idx_q == IDX_BITS'(1)) begin
                wh_x_d = rom_x;
                wh_y_d = rom_y;
            end
            for (int k = 0; k < MAX_FAILHOLE_NUM; k++) begin
                if (load_idx_q == IDX_BITS'(k + 2)) begin
                    fh_x_d[k*PIXEL_COORD_BIT +: PIXEL_COORD_BIT] = rom_x;
                    fh_y_d[k*PIXEL_COORD_BIT +: PIXEL_COORD_BIT] = rom_y;
                end
            end
        end
    end

    // State registers with synchronous active-low reset back to the level 0 load.
    // NOTE: non-blocking assignments here so every flop samples the pre-edge
    // values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            load_idx_q   <= '0;
            level_q      <= '0;
            lives_q      <= 3'(START_LIVES);
            hold_cnt_q   <= '0;
            start_prev_q <= 1'b0;
            game_rst_q   <= 1'b1;
            playing_q    <= 1'b0;
            wh_x_q       <= '0;
            wh_y_q       <= '0;
            fh_x_q       <= '0;
            fh_y_q       <= '0;
        end else begin
            state_q      <= state_d;
            load_idx_q   <= load_idx_d;
            level_q      <= level_d;
            lives_q      <= lives_d;
            hold_cnt_q   <= hold_cnt_d;
            start_prev_q <= start_prev_d;
            game_rst_q   <= game_rst_d;
            playing_q    <= playing_d;
            wh_x_q       <= wh_x_d;
            wh_y_q       <= wh_y_d;
            fh_x_q       <= fh_x_d;
            fh_y_q       <= fh_y_d;
        end
    end

    assign bus.o_game_rst = game_rst_q;
    assign bus.o_playing  = playing_q;
    assign bus.o_wh_pos_x = wh_x_q;
    assign bus.o_wh_pos_y = wh_y_q;
    assign bus.o_fh_pos_x = fh_x_q;
    assign bus.o_fh_pos_y = fh_y_q;
    assign bus.o_level    = level_q;
    assign bus.o_lives    = lives_q;
    assign bus.o_state    = state_q;

endmodule

// File: tb/tb_game_level_sequencer.sv
// Scenario bench for game_level_sequencer: expectations are queued when the
// stimulus is applied and compared once the DUT has had its cycle to respond.
module tb_game_level_sequencer;
    import game_level_sequencer_pkg::*;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] lvl;
        logic [2:0] lives;
        logic       grst;
        logic       play;
    } snap_t;

    localparam int FH_W  = PIXEL_COORD_BIT * MAX_FAILHOLE_NUM;
    localparam int POS_W = 2 * PIXEL_COORD_BIT + 2 * FH_W;

    // Independent copy of the expected level layout.
    localparam int TB_WH_X [4] = '{200, 560,  80, 320};
    localparam int TB_WH_Y [4] = '{100, 400, 420,  40};
    localparam int TB_FH_X [4][5] = '{'{250, 300, 120, 400, 500},
                                      '{100, 320, 450, 200, 600},
                                      '{160, 240, 360, 480, 560},
                                      '{ 60, 180, 300, 420, 540}};
    localparam int TB_FH_Y [4][5] = '{'{ 70, 150, 220, 300,  60},
                                      '{100, 240, 120, 380, 200},
                                      '{300, 180, 360, 240,  80},
                                      '{ 60, 140, 260, 340, 420}};

    logic CLK   = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    snap_t            exp_q  [$];
    string            name_q [$];
    logic [POS_W-1:0] pos_q  [$];

    game_level_sequencer_if bus ();

    game_level_sequencer #(
        .START_LIVES (3),
        .HOLD_FRAMES (120)
    ) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    function automatic snap_t cur();
        return {bus.o_state, bus.o_level, bus.o_lives, bus.o_game_rst, bus.o_playing};
    endfunction

    function automatic snap_t mk(input logic [2:0] st, input int lvl, input int lives,
                                 input logic grst, input logic play);
        return {st, 2'(lvl), 3'(lives), grst, play};
    endfunction

    function automatic logic [POS_W-1:0] cur_pos();
        return {bus.o_wh_pos_x, bus.o_wh_pos_y, bus.o_fh_pos_x, bus.o_fh_pos_y};
    endfunction

    function automatic logic [POS_W-1:0] exp_pos(input int lvl);
        logic [FH_W-1:0] fx;
        logic [FH_W-1:0] fy;
        fx = '0;
        fy = '0;
        for (int k = 0; k < MAX_FAILHOLE_NUM; k++) begin
            fx[k*PIXEL_COORD_BIT +: PIXEL_COORD_BIT] = PIXEL_COORD_BIT'(TB_FH_X[lvl][k]);
            fy[k*PIXEL_COORD_BIT +: PIXEL_COORD_BIT] = PIXEL_COORD_BIT'(TB_FH_Y[lvl][k]);
        end
        return {PIXEL_COORD_BIT'(TB_WH_X[lvl]), PIXEL_COORD_BIT'(TB_WH_Y[lvl]), fx, fy};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push(input string nm, input snap_t s);
        name_q.push_back(nm);
        exp_q.push_back(s);
    endtask

    // One start-button press; the DUT sees the edge on the first clock.
    task automatic press_start();
        bus.i_start = 1'b1;
        tick(1);
        bus.i_start = 1'b0;
    endtask

    task automatic pulse_fail();
        bus.i_fail = 1'b1;
        tick(1);
        bus.i_fail = 1'b0;
    endtask

    task automatic pulse_win();
        bus.i_win = 1'b1;
        tick(1);
        bus.i_win = 1'b0;
    endtask

    // n frame pulses; returns right after the clock that took the last one.
    task automatic hold_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_screenend = 1'b1;
            tick(1);
            bus.i_screenend = 1'b0;
            if (i != n - 1) tick(1);
        end
    endtask

    task automatic test_reset();
        snap_t e; string nm; logic [POS_W-1:0] ep;
        bus.i_screenend = 1'b0;
        bus.i_win       = 1'b0;
        bus.i_fail      = 1'b0;
        bus.i_start     = 1'b1;
        rst_n           = 1'b0;
        push("reset_state", mk(ST_LOAD, 0, 3, 1'b1, 1'b0));
        pos_q.push_back('0);
        tick(2);
        n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
        if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
        n_total++; ep = pos_q.pop_front();
        if (cur_pos() !== ep) begin n_bad++; $display("FAIL reset_pos: got %h want %h", cur_pos(), ep); end
        rst_n = 1'b1;
        push("load_last_cycle", mk(ST_LOAD, 0, 3, 1'b1, 1'b0));
        tick(6);
        n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
        if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
        push("ready_after_load", mk(ST_READY, 0, 3, 1'b1, 1'b0));
        pos_q.push_back(exp_pos(0));
        tick(1);
        n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
        if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
        n_total++; ep = pos_q.pop_front();
        if (cur_pos() !== ep) begin n_bad++; $display("FAIL level0_pos: got %h want %h", cur_pos(), ep); end
        push("start_held_through_load", mk(ST_READY, 0, 3, 1'b1, 1'b0));
        tick(5);
        n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
        if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
        bus.i_start = 1'b0;
        tick(1);
    endtask

    task automatic test_start();
        snap_t e; string nm;
        push("ready_ignores_win_fail", mk(ST_READY, 0, 3, 1'b1, 1'b0));
        bus.i_win = 1'b1; bus.i_fail = 1'b1; bus.i_screenend = 1'b1;
        tick(1);
        bus.i_win = 1'b0; bus.i_fail = 1'b0; bus.i_screenend = 1'b0;
        n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
        if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
        push("start_edge_play", mk(ST_PLAY, 0, 3, 1'b0, 1'b1));
        bus.i_start = 1'b1;
        tick(1);
        n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
        if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
        push("start_held_1000", mk(ST_PLAY, 0, 3, 1'b0, 1'b1));
        for (int i = 0; i < 1000; i++) begin
            bus.i_screenend = (i % 10 == 0);
            tick(1);
        end
        bus.i_screenend = 1'b0;
        bus.i_start     = 1'b0;
        n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
        if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
    endtask

    task automatic test_simul_win_fail();
        snap_t e; string nm; logic [POS_W-1:0] ep;
        push("win_and_fail_fail_wins", mk(ST_FAIL_HOLD, 0, 2, 1'b0, 1'b0));
        bus.i_win = 1'b1; bus.i_fail = 1'b1;
        tick(1);
        bus.i_win = 1'b0; bus.i_fail = 1'b0;
        n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
        if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
        push("hold_after_119_frames", mk(ST_FAIL_HOLD, 0, 2, 1'b0, 1'b0));
        hold_pulses(119);
        n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
        if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
        push("retry_after_120_frames", mk(ST_LOAD, 0, 2, 1'b1, 1'b0));
        hold_pulses(1);
        n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
        if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
        push("retry_ready", mk(ST_READY, 0, 2, 1'b1, 1'b0));
        pos_q.push_back(exp_pos(0));
        tick(7);
        n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
        if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
        n_total++; ep = pos_q.pop_front();
        if (cur_pos() !== ep) begin n_bad++; $display("FAIL retry_pos: got %h want %h", cur_pos(), ep); end
    endtask

    task automatic test_game_over();
        snap_t e; string nm;
        press_start();
        push("second_fail_lives1", mk(ST_FAIL_HOLD, 0, 1, 1'b0, 1'b0));
        pulse_fail();
        n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
        if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
        hold_pulses(120);
        tick(7);
        press_start();
        pulse_fail();
        push("game_over_lives0", mk(ST_GAME_OVER, 0, 0, 1'b1, 1'b0));
        hold_pulses(120);
        n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
        if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
        push("game_over_ignores_fail", mk(ST_GAME_OVER, 0, 0, 1'b1, 1'b0));
        pulse_fail();
        n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
        if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
        push("game_over_restart", mk(ST_LOAD, 0, 3, 1'b1, 1'b0));
        press_start();
        n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
        if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
        tick(7);
    endtask

    task automatic test_wins();
        snap_t e; string nm; logic [POS_W-1:0] ep;
        for (int lv = 0; lv < LEVEL_COUNT; lv++) begin
            press_start();
            push($sformatf("win_hold_l%0d", lv), mk(ST_WIN_HOLD, lv, 3, 1'b0, 1'b0));
            pulse_win();
            n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
            if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
            hold_pulses(120);
            if (lv < LEVEL_COUNT - 1) begin
                push($sformatf("ready_l%0d", lv + 1), mk(ST_READY, lv + 1, 3, 1'b1, 1'b0));
                pos_q.push_back(exp_pos(lv + 1));
                tick(7);
                n_total++; ep = pos_q.pop_front();
                if (cur_pos() !== ep) begin n_bad++; $display("FAIL pos_l%0d: got %h want %h", lv + 1, cur_pos(), ep); end
            end else begin
                push("game_done", mk(ST_GAME_DONE, 3, 3, 1'b1, 1'b0));
            end
            n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
            if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
        end
        push("game_done_restart", mk(ST_LOAD, 0, 3, 1'b1, 1'b0));
        press_start();
        n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
        if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
        tick(7);
    endtask

    task automatic test_reset_mid_load();
        snap_t e; string nm; logic [POS_W-1:0] ep;
        press_start();
        pulse_fail();
        hold_pulses(120);
        tick(7);
        press_start();
        pulse_win();
        hold_pulses(120);
        tick(7);
        press_start();
        pulse_win();
        push("load_l2_lives2", mk(ST_LOAD, 2, 2, 1'b1, 1'b0));
        hold_pulses(120);
        n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
        if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
        tick(3);
        push("reset_mid_load", mk(ST_LOAD, 0, 3, 1'b1, 1'b0));
        pos_q.push_back('0);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
        if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
        n_total++; ep = pos_q.pop_front();
        if (cur_pos() !== ep) begin n_bad++; $display("FAIL reset_mid_load_pos: got %h want %h", cur_pos(), ep); end
        push("reload_ready_l0", mk(ST_READY, 0, 3, 1'b1, 1'b0));
        pos_q.push_back(exp_pos(0));
        tick(7);
        n_total++; e = exp_q.pop_front(); nm = name_q.pop_front();
        if (cur() !== e) begin n_bad++; $display("FAIL %s: got {st,lvl,lives,rst,play}=%b want %b", nm, cur(), e); end
        n_total++; ep = pos_q.pop_front();
        if (cur_pos() !== ep) begin n_bad++; $display("FAIL reload_pos_l0: got %h want %h", cur_pos(), ep); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_simul_win_fail();
        test_game_over();
        test_wins();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
